// File: rtl/seq_divider.sv
// Sequential signed restoring divider with C semantics (truncate toward zero,
// remainder follows the dividend sign); operands arrive serially on data_in.
module seq_divider #(
    parameter int N = 9
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         start,
    input  logic [N-1:0] data_in,
    output logic [N-1:0] quotient,
    output logic [N-1:0] remainder,
    output logic         done,
    output logic         busy,
    output logic         dz,
    output logic         ovf
);

    localparam int CW = (N > 1) ? $clog2(N) : 1;

    typedef enum logic [2:0] {
        IDLE,
        LOAD_A,
        LOAD_B,
        CHECK,
        ITER,
        FIX,
        DONE
    } state_t;

    state_t         state_q, state_d;
    logic [N-1:0]   dividend_q, dividend_d;
    logic [N-1:0]   divisor_q, divisor_d;
    logic [N-1:0]   divMag_q, divMag_d;
    logic [N-1:0]   quoWork_q, quoWork_d;
    logic [N:0]     remWork_q, remWork_d;
    logic [CW-1:0]  count_q, count_d;
    logic           dividendNeg_q, dividendNeg_d;
    logic           signDiff_q, signDiff_d;
    logic [N-1:0]   quotient_q, quotient_d;
    logic [N-1:0]   remainder_q, remainder_d;
    logic           dz_q, dz_d;
    logic           ovf_q, ovf_d;

    logic [N:0]     shifted;
    logic [N:0]     trial;
    logic           fits;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= IDLE;
            dividend_q    <= '0;
            divisor_q     <= '0;
            divMag_q      <= '0;
            quoWork_q     <= '0;
            remWork_q     <= '0;
            count_q       <= '0;
            dividendNeg_q <= 1'b0;
            signDiff_q    <= 1'b0;
            quotient_q    <= '0;
            remainder_q   <= '0;
            dz_q          <= 1'b0;
            ovf_q         <= 1'b0;
        end else begin
            state_q       <= state_d;
            dividend_q    <= dividend_d;
            divisor_q     <= divisor_d;
            divMag_q      <= divMag_d;
            quoWork_q     <= quoWork_d;
            remWork_q     <= remWork_d;
            count_q       <= count_d;
            dividendNeg_q <= dividendNeg_d;
            signDiff_q    <= signDiff_d;
            quotient_q    <= quotient_d;
            remainder_q   <= remainder_d;
            dz_q          <= dz_d;
            ovf_q         <= ovf_d;
        end
    end

    always_comb begin
        state_d       = state_q;
        dividend_d    = dividend_q;
        divisor_d     = divisor_q;
        divMag_d      = divMag_q;
        quoWork_d     = quoWork_q;
        remWork_d     = remWork_q;
        count_d       = count_q;
        dividendNeg_d = dividendNeg_q;
        signDiff_d    = signDiff_q;
        quotient_d    = quotient_q;
        remainder_d   = remainder_q;
        dz_d          = dz_q;
        ovf_d         = ovf_q;
        done          = 1'b0;
        busy          = (state_q != IDLE);

        // A set guard bit means the shifted remainder already exceeds any magnitude.
        shifted = {remWork_q[N-1:0], quoWork_q[N-1]};
        trial   = shifted - {1'b0, divMag_q};
        fits    = remWork_q[N] | (shifted >= {1'b0, divMag_q});

        case (state_q)
            IDLE: begin
                if (start) begin
                    state_d = LOAD_A;
                end
            end
            LOAD_A: begin
                dividend_d = data_in;
                state_d    = LOAD_B;
            end
            LOAD_B: begin
                divisor_d = data_in;
                state_d   = CHECK;
            end
            CHECK: begin
                if (divisor_q == '0) begin
                    quotient_d  = '0;
                    remainder_d = dividend_q;
                    dz_d        = 1'b1;
                    ovf_d       = 1'b0;
                    state_d     = DONE;
                end else begin
                    // Negating -2^(N-1) yields 2^(N-1), which is correct read as unsigned.
                    dividendNeg_d = dividend_q[N-1];
                    signDiff_d    = dividend_q[N-1] ^ divisor_q[N-1];
                    quoWork_d     = dividend_q[N-1] ? -dividend_q : dividend_q;
                    divMag_d      = divisor_q[N-1] ? -divisor_q : divisor_q;
                    remWork_d     = '0;
                    count_d       = '0;
                    state_d       = ITER;
                end
            end
            ITER: begin
                quoWork_d = {quoWork_q[N-2:0], 1'b0};
                if (fits) begin
                    remWork_d    = trial;
                    quoWork_d[0] = 1'b1;
                end else begin
                    remWork_d = shifted;
                end
                count_d = count_q + CW'(1);
                if (count_q == CW'(N - 1)) begin
                    state_d = FIX;
                end
            end
            FIX: begin
                quotient_d  = signDiff_q ? -quoWork_q : quoWork_q;
                remainder_d = dividendNeg_q ? -remWork_q[N-1:0] : remWork_q[N-1:0];
                ovf_d       = (dividend_q == {1'b1, {(N-1){1'b0}}}) && (divisor_q == '1);
                dz_d        = 1'b0;
                state_d     = DONE;
            end
            DONE: begin
                done    = 1'b1;
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign quotient  = quotient_q;
    assign remainder = remainder_q;
    assign dz        = dz_q;
    assign ovf       = ovf_q;

endmodule

// File: tb/tb_seq_divider.sv
// Directed bench for seq_divider: vector table plus back-to-back, start-during-ITER
// and reset-during-ITER sequences.
module tb_seq_divider;

    localparam int N = 9;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         start;
    logic [N-1:0] data_in;
    logic [N-1:0] quotient;
    logic [N-1:0] remainder;
    logic         done;
    logic         busy;
    logic         dz;
    logic         ovf;

    int assertCount = 0;
    int failCount   = 0;

    typedef struct {
        logic [N-1:0] a;
        logic [N-1:0] b;
        logic [N-1:0] q;
        logic [N-1:0] r;
        logic         dz;
        logic         ovf;
        int           doneEdge;
    } vec_t;

    vec_t vecs[10];

    seq_divider #(.N(N)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (start),
        .data_in   (data_in),
        .quotient  (quotient),
        .remainder (remainder),
        .done      (done),
        .busy      (busy),
        .dz        (dz),
        .ovf       (ovf)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic checkVal(input string name, input logic [31:0] actual, input logic [31:0] expected);
        assertCount++;
        if (actual !== expected) begin
            failCount++;
            $display("[TB] FAIL %s: got 'h%0h, required 'h%0h", name, actual, expected);
        end
    endtask

    // Start request sampled at edge 0, dividend at edge 1, divisor at edge 2.
    task automatic applyStimulus(input logic [N-1:0] a, input logic [N-1:0] b);
        @(negedge clk);
        start = 1'b1;
        @(posedge clk);
        @(negedge clk);
        checkVal("busy_after_start", {31'd0, busy}, 32'd1);
        start   = 1'b0;
        data_in = a;
        @(posedge clk);
        @(negedge clk);
        data_in = b;
        @(posedge clk);
    endtask

    // Called just after edge 2; reports the edge after which done was first seen.
    task automatic waitDone(input bit pulseStart, output int doneEdge, output int busyLow);
        doneEdge = -1;
        busyLow  = 0;
        for (int e = 3; e <= 40; e++) begin
            @(posedge clk);
            @(negedge clk);
            if (pulseStart && e == 6) start = 1'b1;
            if (pulseStart && e == 7) start = 1'b0;
            if (!busy) busyLow++;
            if (done) begin
                doneEdge = e;
                break;
            end
        end
    endtask

    task automatic checkOutput(input vec_t v, input int doneEdge, input int busyLow,
                               input string tag, input bit checkIdle);
        checkVal({tag, "_doneEdge"}, doneEdge, v.doneEdge);
        checkVal({tag, "_quotient"}, {23'd0, quotient}, {23'd0, v.q});
        checkVal({tag, "_remainder"}, {23'd0, remainder}, {23'd0, v.r});
        checkVal({tag, "_dz"}, {31'd0, dz}, {31'd0, v.dz});
        checkVal({tag, "_ovf"}, {31'd0, ovf}, {31'd0, v.ovf});
        checkVal({tag, "_busyLowCycles"}, busyLow, 0);
        if (checkIdle) begin
            @(posedge clk);
            @(negedge clk);
            checkVal({tag, "_donePulseEnds"}, {31'd0, done}, 32'd0);
            checkVal({tag, "_busyFalls"}, {31'd0, busy}, 32'd0);
        end
    endtask

    initial begin
        int   dEdge;
        int   bLow;
        int   stray;
        vec_t v;

        rst_n   = 1'b0;
        start   = 1'b0;
        data_in = '0;

        vecs[0] = '{a: 9'd100,    b: 9'd7,      q: 9'd14,     r: 9'd2,      dz: 1'b0, ovf: 1'b0, doneEdge: 13};
        vecs[1] = '{a: -9'sd185,  b: 9'd7,      q: -9'sd26,   r: -9'sd3,    dz: 1'b0, ovf: 1'b0, doneEdge: 13};
        vecs[2] = '{a: 9'd255,    b: -9'sd16,   q: -9'sd15,   r: 9'd15,     dz: 1'b0, ovf: 1'b0, doneEdge: 13};
        vecs[3] = '{a: 9'h100,    b: 9'h1FF,    q: 9'h100,    r: 9'd0,      dz: 1'b0, ovf: 1'b1, doneEdge: 13};
        vecs[4] = '{a: 9'h100,    b: 9'd1,      q: 9'h100,    r: 9'd0,      dz: 1'b0, ovf: 1'b0, doneEdge: 13};
        vecs[5] = '{a: 9'd50,     b: 9'd0,      q: 9'd0,      r: 9'd50,     dz: 1'b1, ovf: 1'b0, doneEdge: 3};
        vecs[6] = '{a: 9'd9,      b: 9'd3,      q: 9'd3,      r: 9'd0,      dz: 1'b0, ovf: 1'b0, doneEdge: 13};
        vecs[7] = '{a: -9'sd100,  b: -9'sd7,    q: 9'd14,     r: -9'sd2,    dz: 1'b0, ovf: 1'b0, doneEdge: 13};
        vecs[8] = '{a: -9'sd1,    b: 9'd5,      q: 9'd0,      r: -9'sd1,    dz: 1'b0, ovf: 1'b0, doneEdge: 13};
        vecs[9] = '{a: 9'd7,      b: -9'sd100,  q: 9'd0,      r: 9'd7,      dz: 1'b0, ovf: 1'b0, doneEdge: 13};

        #12;
        checkVal("reset_quotient", {23'd0, quotient}, 32'd0);
        checkVal("reset_remainder", {23'd0, remainder}, 32'd0);
        checkVal("reset_done", {31'd0, done}, 32'd0);
        checkVal("reset_busy", {31'd0, busy}, 32'd0);
        checkVal("reset_dz", {31'd0, dz}, 32'd0);
        checkVal("reset_ovf", {31'd0, ovf}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;

        for (int i = 0; i < 10; i++) begin
            applyStimulus(vecs[i].a, vecs[i].b);
            waitDone(1'b0, dEdge, bLow);
            checkOutput(vecs[i], dEdge, bLow, $sformatf("vec%0d", i), 1'b1);
        end

        // Back-to-back: start held high, second request accepted at edge N+6.
        @(negedge clk);
        start = 1'b1;
        @(posedge clk);
        @(negedge clk);
        data_in = vecs[1].a;
        @(posedge clk);
        @(negedge clk);
        data_in = vecs[1].b;
        @(posedge clk);
        waitDone(1'b0, dEdge, bLow);
        checkOutput(vecs[1], dEdge, bLow, "b2b_first", 1'b0);
        @(posedge clk);
        @(negedge clk);
        checkVal("b2b_idle_busy", {31'd0, busy}, 32'd0);
        checkVal("b2b_idle_done", {31'd0, done}, 32'd0);
        @(posedge clk);
        @(negedge clk);
        checkVal("b2b_reaccept_busy", {31'd0, busy}, 32'd1);
        data_in = vecs[2].a;
        @(posedge clk);
        @(negedge clk);
        data_in = vecs[2].b;
        start   = 1'b0;
        @(posedge clk);
        waitDone(1'b0, dEdge, bLow);
        checkOutput(vecs[2], dEdge, bLow, "b2b_second", 1'b1);

        // start pulsed during ITER must not disturb the running operation.
        applyStimulus(vecs[0].a, vecs[0].b);
        waitDone(1'b1, dEdge, bLow);
        checkOutput(vecs[0], dEdge, bLow, "startInIter", 1'b1);

        // Reset during ITER clears outputs and suppresses done.
        applyStimulus(9'd9, 9'd3);
        repeat (4) begin
            @(posedge clk);
            @(negedge clk);
        end
        rst_n = 1'b0;
        #1;
        checkVal("midReset_quotient", {23'd0, quotient}, 32'd0);
        checkVal("midReset_remainder", {23'd0, remainder}, 32'd0);
        checkVal("midReset_done", {31'd0, done}, 32'd0);
        checkVal("midReset_busy", {31'd0, busy}, 32'd0);
        checkVal("midReset_dz", {31'd0, dz}, 32'd0);
        checkVal("midReset_ovf", {31'd0, ovf}, 32'd0);
        stray = 0;
        repeat (3) begin
            @(posedge clk);
            @(negedge clk);
            if (done || busy) stray++;
        end
        rst_n = 1'b1;
        repeat (15) begin
            @(posedge clk);
            @(negedge clk);
            if (done || busy) stray++;
        end
        checkVal("midReset_noDoneNoBusy", stray, 0);

        v = '{a: -9'sd7, b: 9'd2, q: -9'sd3, r: -9'sd1, dz: 1'b0, ovf: 1'b0, doneEdge: 13};
        applyStimulus(v.a, v.b);
        waitDone(1'b0, dEdge, bLow);
        checkOutput(v, dEdge, bLow, "afterReset", 1'b1);

        $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
        $finish;
    end

endmodule
